// File: rtl/balanca_price_ctrl_pkg.sv
// rtl/balanca_price_ctrl_pkg.sv - shared types and constants for the price controller
// Purpose: FSM state encoding, unit-conversion constants and the iteration
//          counts for each phase of the sequential price computation.
// Ports:   none (package).
package balanca_price_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV_K = 3'd2,
    ST_DIV_C = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int CENTS_PER_EURO = 100;
  localparam int GRAMS_PER_KG   = 1000;
  localparam int ROUND_BIAS     = 500;

  localparam int MUL_CYC  = 12;  // one step per weight bit
  localparam int DIVK_CYC = 22;  // one step per product bit
  localparam int DIVC_CYC = 13;  // one step per totalCents bit

  // Divisors (1000 and 100) both fit here; the remainder is always below them.
  localparam int DIVISOR_W = 10;

endpackage

// File: rtl/balanca_price_ctrl_if.sv
// rtl/balanca_price_ctrl_if.sv - handshake and operand/result bundle of the price controller
// Purpose: groups the start/busy/done handshake with operands and results.
// Signals: start, weightInGrams, centimos (requester -> controller);
//          busy, done, preco, precofr (controller -> requester).
// Modports: master = requester side, slave = controller side.
interface balanca_price_ctrl_if #(
  parameter int WEIGHT_W = 12,
  parameter int PRICE_W  = 10,
  parameter int OUT_W    = 12
);

  logic                start;
  logic [WEIGHT_W-1:0] weightInGrams;
  logic [PRICE_W-1:0]  centimos;
  logic                busy;
  logic                done;
  logic [OUT_W-1:0]    preco;
  logic [OUT_W-1:0]    precofr;

  modport master (
    output start, weightInGrams, centimos,
    input  busy, done, preco, precofr
  );

  modport slave (
    input  start, weightInGrams, centimos,
    output busy, done, preco, precofr
  );

endinterface

// File: rtl/balanca_price_ctrl_seq_divider.sv
// rtl/balanca_price_ctrl_seq_divider.sv - restoring divider, one quotient bit per step
// Purpose: sequential unsigned restoring divider shared by both division passes.
// Ports:   i_clk, i_reset   clock, synchronous active-high reset
//          i_load           capture i_dividend / i_divisor, clear remainder (wins over i_step)
//          i_step           produce one quotient bit, MSB first
//          o_quo, o_rem     registered quotient / partial remainder
//          o_quo_nxt        quotient as it will be after this cycle's step, so a
//                           caller can chain a new load on the final step edge
module balanca_price_ctrl_seq_divider
  import balanca_price_ctrl_pkg::*;
#(
  parameter int DIVIDEND_W = 22,
  parameter int DIVSR_W    = DIVISOR_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVSR_W-1:0]    i_divisor,
  output logic [DIVIDEND_W-1:0] o_quo,
  output logic [DIVSR_W-1:0]    o_rem,
  output logic [DIVIDEND_W-1:0] o_quo_nxt
);

  // r_quo starts as the dividend and fills with quotient bits from the right
  // while dividend bits leave from the left into the remainder.
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVSR_W-1:0]    r_rem;
  logic [DIVSR_W-1:0]    r_div;

  logic [DIVSR_W:0]      w_shift;
  logic                  w_ge;
  logic [DIVSR_W-1:0]    w_sub;
  logic [DIVSR_W-1:0]    w_rem_nxt;

  assign w_shift   = {r_rem, r_quo[DIVIDEND_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  // The difference is below the divisor whenever it is kept, so the low bits suffice.
  assign w_sub     = w_shift[DIVSR_W-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[DIVSR_W-1:0];
  assign o_quo_nxt = {r_quo[DIVIDEND_W-2:0], w_ge};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_quo <= o_quo_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/balanca_price_ctrl.sv
// rtl/balanca_price_ctrl.sv - sequential weight x price -> euros/cents controller
// Purpose: product = weight*price (shift-add), totalCents = (product+500)/1000,
//          preco = totalCents/100, precofr = totalCents%100, using one shared
//          restoring divider for both divisions. Fixed 48-cycle latency.
// Ports:   i_clk, i_reset   clock, synchronous active-high reset
//          bus (slave)      start/weightInGrams/centimos in,
//                           busy/done/preco/precofr out (all registered)
module balanca_price_ctrl
  import balanca_price_ctrl_pkg::*;
#(
  parameter int WEIGHT_W = 12,
  parameter int PRICE_W  = 10,
  parameter int OUT_W    = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  balanca_price_ctrl_if.slave  bus
);

  localparam int PROD_W = WEIGHT_W + PRICE_W;
  localparam int TOT_W  = DIVC_CYC;
  localparam int PAD_W  = PROD_W - TOT_W;

  localparam logic [4:0] MUL_LAST  = 5'(MUL_CYC - 1);
  localparam logic [4:0] DIVK_LAST = 5'(DIVK_CYC - 1);
  localparam logic [4:0] DIVC_LAST = 5'(DIVC_CYC - 1);

  state_t              r_state;
  logic [4:0]          r_cnt;
  logic [WEIGHT_W-1:0] r_mplier;
  logic [PROD_W-1:0]   r_mcand;
  logic [PROD_W-1:0]   r_acc;
  logic                r_busy;
  logic                r_done;
  logic [OUT_W-1:0]    r_preco;
  logic [OUT_W-1:0]    r_precofr;

  logic [PROD_W-1:0]    w_acc_nxt;
  logic                 w_div_load;
  logic                 w_div_step;
  logic [PROD_W-1:0]    w_div_dividend;
  logic [DIVISOR_W-1:0] w_divisor;
  logic [PROD_W-1:0]    w_quo;
  logic [PROD_W-1:0]    w_quo_nxt;
  logic [DIVISOR_W-1:0] w_rem;
  logic                 w_unused_quo_hi;

  // LSB-first shift-add: multiplier shifts right, multiplicand shifts left.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Divider sequencing. Each pass loads on the final edge of the previous
  // phase so every phase spends exactly its iteration count stepping.
  // totalCents is left-aligned for the /100 pass so only its 13 bits are walked.
  always_comb begin
    w_div_load     = 1'b0;
    w_div_step     = 1'b0;
    w_div_dividend = '0;
    w_divisor      = '0;
    case (r_state)
      ST_MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_div_load     = 1'b1;
          w_div_dividend = w_acc_nxt + PROD_W'(ROUND_BIAS);
          w_divisor      = DIVISOR_W'(GRAMS_PER_KG);
        end
      end
      ST_DIV_K: begin
        w_div_step = 1'b1;
        if (r_cnt == DIVK_LAST) begin
          w_div_load     = 1'b1;
          w_div_dividend = {w_quo_nxt[TOT_W-1:0], {PAD_W{1'b0}}};
          w_divisor      = DIVISOR_W'(CENTS_PER_EURO);
        end
      end
      ST_DIV_C: w_div_step = 1'b1;
      default: ;
    endcase
  end

  balanca_price_ctrl_seq_divider #(
    .DIVIDEND_W (PROD_W),
    .DIVSR_W    (DIVISOR_W)
  ) u_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_div_dividend),
    .i_divisor  (w_divisor),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_quo_nxt  (w_quo_nxt)
  );

  // Quotients never exceed 13 bits; the upper divider bits stay zero.
  assign w_unused_quo_hi = &{1'b0, w_quo[PROD_W-1:TOT_W], w_quo_nxt[PROD_W-1:TOT_W]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_preco   <= '0;
      r_precofr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mplier <= bus.weightInGrams;
            r_mcand  <= PROD_W'(bus.centimos);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          if (r_cnt == MUL_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DIV_K;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DIV_K: begin
          if (r_cnt == DIVK_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DIV_C;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DIV_C: begin
          if (r_cnt == DIVC_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DONE: begin
          r_preco   <= OUT_W'(w_quo[TOT_W-1:0]);
          r_precofr <= OUT_W'(w_rem);
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.preco   = r_preco;
  assign bus.precofr = r_precofr;

endmodule

// File: tb/tb_balanca_price_ctrl.sv
// tb/tb_balanca_price_ctrl.sv - self-checking bench for balanca_price_ctrl
module tb_balanca_price_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  bit   chk_en;

  balanca_price_ctrl_if #(.WEIGHT_W(12), .PRICE_W(10), .OUT_W(12)) bus ();

  balanca_price_ctrl #(.WEIGHT_W(12), .PRICE_W(10), .OUT_W(12)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a start accepted while idle yields its rounded result
  // 48 edges later as a one-cycle done pulse; busy covers the edges between.
  int   m_left;
  logic m_busy, m_done;
  int   m_preco, m_precofr;
  int   m_pend_e, m_pend_c, m_tot;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_preco = 0; m_precofr = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_preco = m_pend_e; m_precofr = m_pend_c;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start === 1'b1) begin
        m_tot    = (int'(bus.weightInGrams) * int'(bus.centimos) + 500) / 1000;
        m_pend_e = m_tot / 100;
        m_pend_c = m_tot % 100;
        m_left   = 48;
        m_busy   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (bus.busy !== m_busy || bus.done !== m_done ||
          bus.preco !== 12'(m_preco) || bus.precofr !== 12'(m_precofr)) begin
        n_err++;
        $display("FAIL cycle_check t=%0t busy %b exp %b done %b exp %b preco %0d exp %0d precofr %0d exp %0d",
                 $time, bus.busy, m_busy, bus.done, m_done, bus.preco, m_preco, bus.precofr, m_precofr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_one(input string name, input int w, input int p, input int ee, input int ec);
    int m, bc;
    bus.weightInGrams = 12'(w);
    bus.centimos      = 10'(p);
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m = 0; bc = 0;
    while (bus.done !== 1'b1 && m < 100) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      m++;
    end
    chk({name, "_latency"}, m, 48);
    chk({name, "_busy_cycles"}, bc, 48);
    chk({name, "_preco"}, 32'(bus.preco), ee);
    chk({name, "_precofr"}, 32'(bus.precofr), ec);
    chk({name, "_model_preco"}, m_preco, ee);
    chk({name, "_model_precofr"}, m_precofr, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, t1, t2, e1, c1, e2, c2;
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.weightInGrams = '0; bus.centimos = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_preco", 32'(bus.preco), 0);
    chk("reset_precofr", 32'(bus.precofr), 0);
    reset = 1'b0;
    @(negedge clk);

    run_one("nominal", 1500, 470, 7, 5);
    run_one("maximum", 4095, 1023, 41, 89);
    run_one("round_up", 1, 500, 0, 1);
    run_one("round_down", 1, 499, 0, 0);
    run_one("zero_weight", 0, 1023, 0, 0);

    // Second start while busy and operand changes after acceptance are ignored.
    bus.weightInGrams = 12'd1500; bus.centimos = 10'd470; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dn = 0; t1 = -1; e1 = 0; c1 = 0;
    for (int m = 0; m < 120; m++) begin
      if (bus.done === 1'b1) begin
        dn++;
        if (t1 < 0) begin t1 = m; e1 = 32'(bus.preco); c1 = 32'(bus.precofr); end
      end
      if (m == 1) begin bus.weightInGrams = 12'd4095; bus.centimos = 10'd1023; end
      if (m == 10) begin bus.weightInGrams = 12'd1; bus.centimos = 10'd500; bus.start = 1'b1; end
      if (m == 11) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("busy_prot_dones", dn, 1);
    chk("busy_prot_latency", t1, 48);
    chk("busy_prot_preco", e1, 7);
    chk("busy_prot_precofr", c1, 5);

    // Reset in the middle of a computation.
    bus.weightInGrams = 12'd4095; bus.centimos = 10'd1023; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(bus.busy), 0);
    chk("midreset_preco", 32'(bus.preco), 0);
    chk("midreset_precofr", 32'(bus.precofr), 0);
    reset = 1'b0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    chk("midreset_no_done", dn, 0);
    run_one("after_reset", 200, 999, 2, 0);

    // start held high: two back-to-back computations 49 cycles apart.
    bus.weightInGrams = 12'd1500; bus.centimos = 10'd470; bus.start = 1'b1;
    @(negedge clk);
    dn = 0; t1 = -1; t2 = -1; e1 = 0; c1 = 0; e2 = 0; c2 = 0;
    for (int m = 0; m < 120; m++) begin
      if (bus.done === 1'b1) begin
        dn++;
        if (t1 < 0) begin t1 = m; e1 = 32'(bus.preco); c1 = 32'(bus.precofr); end
        else if (t2 < 0) begin t2 = m; e2 = 32'(bus.preco); c2 = 32'(bus.precofr); end
      end
      if (m == 1) begin bus.weightInGrams = 12'd200; bus.centimos = 10'd999; end
      if (m == 50) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_dones", dn, 2);
    chk("b2b_first_latency", t1, 48);
    chk("b2b_second_latency", t2, 97);
    chk("b2b_first_preco", e1, 7);
    chk("b2b_first_precofr", c1, 5);
    chk("b2b_second_preco", e2, 2);
    chk("b2b_second_precofr", c2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
